hier_dispatch_node: RTL and testbench



---
 rtl/hier_node_pkg.sv | 35 +++
 rtl/hier_leaf.sv | 71 +++++++
 rtl/hier_dispatch_node.sv | 122 ++++++++++++
 tb/tb_hier_dispatch_node.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchical dispatch node.
//   leaf_state_e : per-leaf worker state (IDLE, BUSY, DONE)
//   rr_pick_t    : round-robin arbitration result (found flag + winner index)
//   rr_pick()    : first set bit of done_vec at or after ptr, wrapping at num_child
package hier_node_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} leaf_state_e;

   // Widest fan-out a node may be built with; the arbiter works on vectors of this size.
   localparam int unsigned MaxChild = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // ptr must be below num_child, so a single subtraction wraps the search index.
   function automatic rr_pick_t rr_pick(input logic [MaxChild-1:0] done_vec,
                                        input logic [3:0]          ptr,
                                        input int unsigned         num_child);
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned k = 0; k < MaxChild; k++) begin
         j = {28'd0, ptr} + k;
         if (j >= num_child) j = j - num_child;
         if (k < num_child && !res.found && done_vec[j[3:0]]) begin
            res.found = 1'b1;
            res.idx   = j[3:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hier_leaf.sv
// Single leaf worker: accepts one operand, stays BUSY for LEAF_LAT cycles, then holds
// data + seq in DONE until the parent grants it. seq counts completed operations.
//   clk, rst   : clock, synchronous active-high reset
//   start      : accept start_data (honoured only in IDLE)
//   start_data : command operand
//   grant      : parent has taken the result (honoured only in DONE)
//   state      : current FSM state
//   result     : registered result, valid in DONE
module hier_leaf
   import hier_node_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LEAF_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] start_data,
   input  logic              grant,
   output leaf_state_e       state,
   output logic [DATA_W-1:0] result
);

   localparam int unsigned     CNT_W    = (LEAF_LAT > 1) ? $clog2(LEAF_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LEAF_LAT - 1);

   leaf_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] seq_q;
   logic [DATA_W-1:0] result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         seq_q    <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  data_q  <= start_data;
                  cnt_q   <= CNT_LOAD;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  result_q <= data_q + seq_q;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (grant) begin
                  seq_q   <= seq_q + 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state  = state_q;
   assign result = result_q;

endmodule

// File: rtl/hier_dispatch_node.sv
// Interior hierarchy node: routes each command to one of NUM_CHILD leaf workers and merges
// finished leaf results into a single registered response stream (round-robin).
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake; ready depends combinationally on cmd_dest
//   cmd_dest/cmd_data : target leaf and operand
//   rsp_valid/ready   : response handshake
//   rsp_src/rsp_data  : producing leaf and its result
//   busy_mask         : bit i set while leaf i is not IDLE
//   err_dest          : one-cycle pulse after an out-of-range command is accepted
module hier_dispatch_node
   import hier_node_pkg::*;
#(
   parameter  int unsigned NUM_CHILD = 5,
   parameter  int unsigned DATA_W    = 16,
   parameter  int unsigned LEAF_LAT  = 4,
   localparam int unsigned IDX_W     = $clog2(NUM_CHILD)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [IDX_W-1:0]     cmd_dest,
   input  logic [DATA_W-1:0]    cmd_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDX_W-1:0]     rsp_src,
   output logic [DATA_W-1:0]    rsp_data,
   output logic [NUM_CHILD-1:0] busy_mask,
   output logic                 err_dest
);

   leaf_state_e          leaf_state  [NUM_CHILD];
   logic [DATA_W-1:0]    leaf_result [NUM_CHILD];
   logic [NUM_CHILD-1:0] leaf_idle;
   logic [NUM_CHILD-1:0] leaf_start;
   logic [NUM_CHILD-1:0] leaf_grant;
   logic [MaxChild-1:0]  done_vec;
   logic                 dest_ok;
   logic                 slot_free;
   rr_pick_t             pick;
   logic [DATA_W-1:0]    win_data;

   logic [3:0]           rr_ptr_q;
   logic                 rsp_valid_q;
   logic [IDX_W-1:0]     rsp_src_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic                 err_q;

   assign dest_ok = 32'(cmd_dest) < NUM_CHILD;
   // Out-of-range commands are always taken so they can be dropped and flagged.
   assign cmd_ready = dest_ok ? leaf_idle[cmd_dest] : 1'b1;

   for (genvar g = 0; g < NUM_CHILD; g++) begin : g_leaf
      assign leaf_idle[g]  = (leaf_state[g] == IDLE);
      assign busy_mask[g]  = ~leaf_idle[g];
      // The leaf itself ignores start outside IDLE, matching cmd_ready.
      assign leaf_start[g] = cmd_valid & dest_ok & (32'(cmd_dest) == g);

      hier_leaf #(
         .DATA_W   (DATA_W),
         .LEAF_LAT (LEAF_LAT)
      ) u_leaf (
         .clk        (clk),
         .rst        (rst),
         .start      (leaf_start[g]),
         .start_data (cmd_data),
         .grant      (leaf_grant[g]),
         .state      (leaf_state[g]),
         .result     (leaf_result[g])
      );
   end

   always_comb begin
      done_vec = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         done_vec[i] = (leaf_state[i] == DONE);
      end
   end

   // Slot can take a new result when empty or being drained this cycle.
   assign slot_free = ~rsp_valid_q | rsp_ready;
   assign pick      = rr_pick(done_vec, rr_ptr_q, NUM_CHILD);

   always_comb begin
      leaf_grant = '0;
      win_data   = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         if (slot_free && pick.found && (pick.idx == 4'(i))) begin
            leaf_grant[i] = 1'b1;
            win_data      = leaf_result[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_src_q   <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= cmd_valid & ~dest_ok;
         if (slot_free) begin
            if (pick.found) begin
               rsp_valid_q <= 1'b1;
               rsp_src_q   <= pick.idx[IDX_W-1:0];
               rsp_data_q  <= win_data;
               rr_ptr_q    <= (32'(pick.idx) + 32'd1 >= NUM_CHILD) ? 4'd0 : pick.idx + 4'd1;
            end else begin
               rsp_valid_q <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_src   = rsp_src_q;
   assign rsp_data  = rsp_data_q;
   assign err_dest  = err_q;

endmodule

// File: tb/tb_hier_dispatch_node.sv
// Bench for hier_dispatch_node (NUM_CHILD=5, DATA_W=16, LEAF_LAT=4): a hand-computed
// vector table, directed multi-cycle sequences, then random traffic, all additionally
// compared each cycle against a timestamp-based reference model.
module tb_hier_dispatch_node;

   localparam int N   = 5;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_dest;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_src;
   logic [15:0] rsp_data;
   logic [4:0]  busy_mask;
   logic        err_dest;

   always #5 clk = ~clk;

   hier_dispatch_node #(
      .NUM_CHILD (N),
      .DATA_W    (16),
      .LEAF_LAT  (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dest  (cmd_dest),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_src   (rsp_src),
      .rsp_data  (rsp_data),
      .busy_mask (busy_mask),
      .err_dest  (err_dest)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a leaf is "pending" from acceptance until its result is taken;
   // it becomes eligible for the response slot once LAT edges have passed since acceptance.
   bit          m_pend [N];
   int          m_acc  [N];
   logic [15:0] m_val  [N];
   logic [15:0] m_seq  [N];
   bit          m_rv;
   int          m_src;
   logic [15:0] m_rdata;
   bit          m_err;
   int          m_ptr;
   int          edge_n = 0;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_acc[i] = 0; m_val[i] = '0; m_seq[i] = '0;
      end
      m_rv = 0; m_src = 0; m_rdata = '0; m_err = 0; m_ptr = 0;
   endtask

   // Drive one cycle of inputs, check cmd_ready before the edge, step the model,
   // and check all registered outputs after the edge.
   task automatic apply(input bit r, input bit v, input int dest, input logic [15:0] d,
                        input bit rr, output bit rdy_seen);
      bit         exp_rdy;
      bit         free;
      int         j;
      logic [4:0] mmask;
      rst = r; cmd_valid = v; cmd_dest = 3'(dest); cmd_data = d; rsp_ready = rr;
      #1;
      exp_rdy  = (dest >= N) ? 1'b1 : !m_pend[dest];
      rdy_seen = cmd_ready;
      check("cmd_ready", cmd_ready, exp_rdy);
      edge_n++;
      if (r) begin
         model_reset();
      end else begin
         free  = !m_rv || rr;
         m_err = v && (dest >= N);
         if (v && dest < N && !m_pend[dest]) begin
            m_pend[dest] = 1; m_val[dest] = d; m_acc[dest] = edge_n;
         end
         if (free) begin
            m_rv = 0;
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (m_pend[j] && edge_n > m_acc[j] + LAT) begin
                  m_rv    = 1;
                  m_src   = j;
                  m_rdata = m_val[j] + m_seq[j];
                  m_seq[j]++;
                  m_pend[j] = 0;
                  m_ptr     = (j + 1) % N;
                  break;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) mmask[i] = m_pend[i];
      check("busy_mask", busy_mask, mmask);
      check("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
         check("rsp_src", rsp_src, m_src);
         check("rsp_data", rsp_data, m_rdata);
      end
      check("err_dest", err_dest, m_err);
   endtask

   typedef struct {
      bit          v;
      int          dest;
      logic [15:0] d;
      bit          e_rdy;
      bit          e_rv;
      int          e_src;
      logic [15:0] e_data;
      logic [4:0]  e_busy;
      bit          e_err;
   } vec_t;

   function automatic vec_t mk(input bit v, input int dest, input logic [15:0] d,
                               input bit e_rdy, input bit e_rv, input int e_src,
                               input logic [15:0] e_data, input logic [4:0] e_busy,
                               input bit e_err);
      vec_t x;
      x.v = v; x.dest = dest; x.d = d; x.e_rdy = e_rdy; x.e_rv = e_rv; x.e_src = e_src;
      x.e_data = e_data; x.e_busy = e_busy; x.e_err = e_err;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      bit rdy;
      model_reset();

      // Basic path: two commands to leaf 2, second result includes seq=1.
      tbl.push_back(mk(1, 2, 16'h0010, 1, 0, 0, 0, 5'b00100, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5'b00100, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 2, 16'h0010, 5'b00000, 0));
      tbl.push_back(mk(1, 2, 16'h0010, 1, 0, 0, 0, 5'b00100, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5'b00100, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 2, 16'h0011, 5'b00000, 0));
      // Bad destination: taken, flagged for one cycle, no leaf activity.
      tbl.push_back(mk(1, 5, 16'h00aa, 1, 0, 0, 0, 5'b00000, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5'b00000, 0));
      // Busy leaf: second command to leaf 1 stalls until leaf 1 is back to IDLE.
      tbl.push_back(mk(1, 1, 16'h0007, 1, 0, 0, 0, 5'b00010, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 16'h0008, 0, 0, 0, 0, 5'b00010, 0));
      tbl.push_back(mk(1, 1, 16'h0008, 0, 1, 1, 16'h0007, 5'b00000, 0));
      tbl.push_back(mk(1, 1, 16'h0008, 1, 0, 0, 0, 5'b00010, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5'b00010, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 16'h0009, 5'b00000, 0));

      // Reset state.
      apply(1, 0, 0, 0, 1, rdy);
      apply(1, 0, 0, 0, 1, rdy);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_src", rsp_src, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_err_dest", err_dest, 0);
      check("rst_busy_mask", busy_mask, 0);

      foreach (tbl[k]) begin
         apply(0, tbl[k].v, tbl[k].dest, tbl[k].d, 1, rdy);
         check("tbl_cmd_ready", rdy, tbl[k].e_rdy);
         check("tbl_rsp_valid", rsp_valid, tbl[k].e_rv);
         if (tbl[k].e_rv) begin
            check("tbl_rsp_src", rsp_src, tbl[k].e_src);
            check("tbl_rsp_data", rsp_data, tbl[k].e_data);
         end
         check("tbl_busy_mask", busy_mask, tbl[k].e_busy);
         check("tbl_err_dest", err_dest, tbl[k].e_err);
      end

      // Arbitration under backpressure: leaves 4,0,3 drain back-to-back as 4,0,3.
      apply(1, 0, 0, 0, 0, rdy);
      apply(0, 1, 4, 16'h0100, 0, rdy);
      apply(0, 1, 0, 16'h0200, 0, rdy);
      apply(0, 1, 3, 16'h0300, 0, rdy);
      apply(0, 0, 0, 0, 0, rdy);
      apply(0, 0, 0, 0, 0, rdy);
      check("arb_not_yet", rsp_valid, 0);
      apply(0, 0, 0, 0, 0, rdy);
      check("arb_first_valid", rsp_valid, 1);
      check("arb_first_src", rsp_src, 4);
      for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 0, rdy);
      check("arb_hold_src", rsp_src, 4);
      check("arb_hold_data", rsp_data, 16'h0100);
      check("arb_hold_busy", busy_mask, 5'b01001);
      apply(0, 0, 0, 0, 1, rdy);
      check("arb_b2b_src0", rsp_src, 0);
      check("arb_b2b_data0", rsp_data, 16'h0200);
      apply(0, 0, 0, 0, 1, rdy);
      check("arb_b2b_src3", rsp_src, 3);
      check("arb_b2b_data3", rsp_data, 16'h0300);
      apply(0, 0, 0, 0, 1, rdy);
      check("arb_drained", rsp_valid, 0);

      // Wrap: leaf 0 has seq=1, 0xFFFF + 1 wraps to 0.
      apply(0, 1, 0, 16'hffff, 1, rdy);
      for (int i = 0; i < LAT; i++) apply(0, 0, 0, 0, 1, rdy);
      apply(0, 0, 0, 0, 1, rdy);
      check("wrap_valid", rsp_valid, 1);
      check("wrap_data", rsp_data, 16'h0000);

      // Reset mid-operation: in-flight command is discarded and seq restarts.
      apply(0, 1, 3, 16'h1234, 1, rdy);
      apply(0, 0, 0, 0, 1, rdy);
      apply(1, 0, 0, 0, 1, rdy);
      check("midrst_valid", rsp_valid, 0);
      check("midrst_busy", busy_mask, 0);
      for (int i = 0; i < 8; i++) begin
         apply(0, 0, 0, 0, 1, rdy);
         check("midrst_no_rsp", rsp_valid, 0);
      end
      apply(0, 1, 3, 16'h0005, 1, rdy);
      for (int i = 0; i < LAT; i++) apply(0, 0, 0, 0, 1, rdy);
      apply(0, 0, 0, 0, 1, rdy);
      check("midrst_new_valid", rsp_valid, 1);
      check("midrst_new_src", rsp_src, 3);
      check("midrst_new_data", rsp_data, 16'h0005);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
               int'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 9) < 7), rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
